// File: rtl/layer_pkg.sv
// ---------------------------------------------------------------------------
// layer_pkg
// Shared constants, types and fixed-point helpers for the K-best sphere
// decoder layer stages.
//   K      : survivors kept per layer (the 192-bit buses assume 16)
//   W      : data word width, signed Q3.8
//   NCH    : children expanded per parent
//   LEVEL  : truncated Q3.8 constellation levels (2k-7)/sqrt(42)
//   THRESH : decision thresholds separating the 4-level windows
// ---------------------------------------------------------------------------
package layer_pkg;

  localparam int K   = 16;
  localparam int W   = 12;
  localparam int NCH = 4;

  localparam logic signed [W-1:0] LEVEL [8] = '{
    -12'sd276, -12'sd197, -12'sd118, -12'sd39,
     12'sd39,   12'sd118,  12'sd197,  12'sd276
  };

  localparam logic signed [W-1:0] THRESH [4] = '{
    -12'sd118, -12'sd39, 12'sd39, 12'sd118
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One candidate path: accumulated PED plus the symbols decided so far.
  typedef struct packed {
    logic [W-1:0] ped;
    logic [W-1:0] s8;
    logic [W-1:0] s7;
    logic [W-1:0] s6;
  } cand_t;

  // Q3.8 x Q3.8 product rescaled to Q.8; the full 24-bit product is formed
  // first so the arithmetic shift floors towards minus infinity.
  function automatic logic signed [15:0] qmul(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
    logic signed [23:0] p;
    p = a * b;
    return 16'(p >>> 8);
  endfunction

  // Clamp a signed value into the signed 12-bit range.
  function automatic logic signed [W-1:0] sat_s12(input logic signed [15:0] v);
    if (v > 16'sd2047)
      return 12'sh7FF;
    else if (v < -16'sd2048)
      return 12'sh800;
    else
      return v[W-1:0];
  endfunction

  // Clamp a non-negative value to the unsigned 12-bit maximum 0xFFF.
  function automatic logic [W-1:0] sat_u12(input logic [15:0] v);
    if (v > 16'd4095)
      return 12'hFFF;
    else
      return v[W-1:0];
  endfunction

endpackage

// File: rtl/layer6_if.sv
// ---------------------------------------------------------------------------
// layer6_if
// Bundles the parent-set input stream and the survivor-set output stream of
// the layer-6 K-best stage.
//   y6, R66..R68          : per-frame channel values (signed Q3.8)
//   in_valid / in_ready   : parent set handshake
//   ped_in, sym7_in/8_in  : 16 parent paths, entry i at bits [12i+:12]
//   out_valid / out_ready : survivor set handshake
//   ped_out, sym6..8_out  : 16 ascending-sorted survivor paths
// Modports: master drives a frame in and consumes the result, slave is the
// decoder stage itself.
// ---------------------------------------------------------------------------
interface layer6_if;
  import layer_pkg::*;

  logic signed [W-1:0] y6;
  logic signed [W-1:0] R66;
  logic signed [W-1:0] R67;
  logic signed [W-1:0] R68;
  logic                in_valid;
  logic                in_ready;
  logic [K*W-1:0]      ped_in;
  logic [K*W-1:0]      sym7_in;
  logic [K*W-1:0]      sym8_in;
  logic                out_valid;
  logic                out_ready;
  logic [K*W-1:0]      ped_out;
  logic [K*W-1:0]      sym6_out;
  logic [K*W-1:0]      sym7_out;
  logic [K*W-1:0]      sym8_out;

  modport master (
    output y6, R66, R67, R68, in_valid, ped_in, sym7_in, sym8_in, out_ready,
    input  in_ready, out_valid, ped_out, sym6_out, sym7_out, sym8_out
  );

  modport slave (
    input  y6, R66, R67, R68, in_valid, ped_in, sym7_in, sym8_in, out_ready,
    output in_ready, out_valid, ped_out, sym6_out, sym7_out, sym8_out
  );

endinterface

// File: rtl/layer6_kbest_insert.sv
// ---------------------------------------------------------------------------
// kbest_insert
// K-entry list kept in ascending PED order by insertion, one candidate per
// clock. Reusable by every layer stage.
//   clk, rstn : clock, asynchronous active-low reset (clears everything)
//   clr       : invalidate all entries (start of a new frame)
//   ins       : insert ins_cand this cycle
//   ins_cand  : candidate path (ped, s8, s7, s6)
//   list      : parallel read of all entries, entry 0 is the best
// ---------------------------------------------------------------------------
module kbest_insert
  import layer_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            ins,
  input  cand_t           ins_cand,
  output cand_t [K-1:0]   list
);

  cand_t [K-1:0] entry;
  cand_t [K-1:0] nxt_entry;
  logic  [K-1:0] vld;
  logic  [K-1:0] nxt_vld;
  logic  [K-1:0] gt;

  // An entry loses its place if it is empty or strictly worse than the new
  // candidate; strictness keeps earlier arrivals ahead on equal PEDs. Because
  // the list is sorted with empties at the tail, gt is 0...0 1...1, so the
  // insertion point is simply where gt first rises.
  always_comb begin
    for (int i = 0; i < K; i++)
      gt[i] = !vld[i] || (entry[i].ped > ins_cand.ped);
  end

  // Below the insertion point each entry takes its upper neighbour; entry
  // K-1 falls off the end. A candidate worse than every valid entry leaves
  // gt all zero and the list untouched.
  always_comb begin
    nxt_entry[0] = gt[0] ? ins_cand : entry[0];
    nxt_vld[0]   = vld[0] | gt[0];
    for (int i = 1; i < K; i++) begin
      if (!gt[i]) begin
        nxt_entry[i] = entry[i];
        nxt_vld[i]   = vld[i];
      end else if (gt[i-1]) begin
        nxt_entry[i] = entry[i-1];
        nxt_vld[i]   = vld[i-1];
      end else begin
        nxt_entry[i] = ins_cand;
        nxt_vld[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entry <= '0;
      vld   <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (ins) begin
      entry <= nxt_entry;
      vld   <= nxt_vld;
    end
  end

  assign list = entry;

endmodule

// File: rtl/layer6.sv
// ---------------------------------------------------------------------------
// layer6
// K-best sphere-decoder stage for MIMO layer 6. Expands each of the 16
// parent paths from the layer-8/7 stage into 4 children around its
// interference-cancelled sample, computes child PEDs one per clock and keeps
// the best 16 in a sorted list.
//   clk  : clock
//   rstn : asynchronous active-low reset, aborts any frame in flight
//   bus  : layer6_if.slave, parent set in / survivor set out
// Timing: accept edge, 64 compute edges (stage A), last insert on edge 65,
// which is also the edge that raises out_valid.
// ---------------------------------------------------------------------------
module layer6
  import layer_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  layer6_if.slave  bus
);

  state_t state, state_nxt;
  logic   in_ready, out_valid, accept;

  logic signed [W-1:0] y6_r, r66_r, r67_r, r68_r;
  logic [K*W-1:0]      ped_r, s8_r, s7_r;

  logic [5:0] cnt;
  logic       comp_active;
  logic       a_valid, a_last;
  cand_t      a_cand;

  logic [3:0]          par;
  logic [1:0]          slot;
  logic [W-1:0]        par_ped;
  logic signed [W-1:0] par_s8, par_s7, level;
  logic signed [15:0]  m8, m7, r_ext;
  logic signed [13:0]  r14;
  logic [2:0]          win, lvl_idx;
  logic signed [W-1:0] e;
  logic signed [23:0]  sq;
  logic [W-1:0]        d;
  cand_t               child;

  cand_t [K-1:0]       list;

  assign accept = in_ready && bus.in_valid;
  assign par    = cnt[5:2];
  assign slot   = cnt[1:0];

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (a_valid && a_last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Child datapath for child cnt: cancel the already-decided layers, pick
  // the 4-level window nearest the residual, then score the slot-th level
  // of that window.
  always_comb begin
    par_ped = ped_r[par*W +: W];
    par_s8  = s8_r[par*W +: W];
    par_s7  = s7_r[par*W +: W];
    m8      = qmul(r68_r, par_s8);
    m7      = qmul(r67_r, par_s7);
    r14     = 14'({{4{y6_r[W-1]}}, y6_r} - m8 - m7);
    r_ext   = {{2{r14[13]}}, r14};
    win     = '0;
    for (int t = 0; t < 4; t++)
      if (qmul(r66_r, THRESH[t]) <= r_ext)
        win = win + 3'd1;
    lvl_idx   = win + {1'b0, slot};
    level     = LEVEL[lvl_idx];
    e         = sat_s12(r_ext - qmul(r66_r, level));
    sq        = e * e;
    d         = sat_u12(16'(sq >>> 8));
    child.ped = sat_u12({4'b0, par_ped} + {4'b0, d});
    child.s8  = par_s8;
    child.s7  = par_s7;
    child.s6  = level;
  end

  // Frame capture and stage A. Children are produced while comp_active is
  // set; a_last tags child 63 so the FSM leaves RUN on the edge that
  // inserts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y6_r        <= '0;
      r66_r       <= '0;
      r67_r       <= '0;
      r68_r       <= '0;
      ped_r       <= '0;
      s8_r        <= '0;
      s7_r        <= '0;
      cnt         <= '0;
      comp_active <= 1'b0;
      a_valid     <= 1'b0;
      a_last      <= 1'b0;
      a_cand      <= '0;
    end else if (accept) begin
      y6_r        <= bus.y6;
      r66_r       <= bus.R66;
      r67_r       <= bus.R67;
      r68_r       <= bus.R68;
      ped_r       <= bus.ped_in;
      s8_r        <= bus.sym8_in;
      s7_r        <= bus.sym7_in;
      cnt         <= '0;
      comp_active <= 1'b1;
      a_valid     <= 1'b0;
      a_last      <= 1'b0;
    end else if (state == RUN && comp_active) begin
      a_cand  <= child;
      a_valid <= 1'b1;
      a_last  <= (cnt == 6'(K*NCH-1));
      if (cnt == 6'(K*NCH-1))
        comp_active <= 1'b0;
      else
        cnt <= cnt + 6'd1;
    end else begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
    end
  end

  // Stage B: sorted survivor list.
  kbest_insert u_list (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (accept),
    .ins      (a_valid),
    .ins_cand (a_cand),
    .list     (list)
  );

  always_comb begin
    bus.ped_out  = '0;
    bus.sym6_out = '0;
    bus.sym7_out = '0;
    bus.sym8_out = '0;
    for (int i = 0; i < K; i++) begin
      bus.ped_out[i*W +: W]  = list[i].ped;
      bus.sym6_out[i*W +: W] = list[i].s6;
      bus.sym7_out[i*W +: W] = list[i].s7;
      bus.sym8_out[i*W +: W] = list[i].s8;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_layer6.sv
// ---------------------------------------------------------------------------
// tb_layer6
// Directed bench for the layer-6 K-best stage. Each frame loads 16 parents,
// expects out_valid exactly 65 edges after the accept edge, and compares
// the sorted survivor list against hand-computed values.
// ---------------------------------------------------------------------------
module tb_layer6;

  logic clk;
  logic rstn;

  layer6_if bus ();

  layer6 u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] par_ped [16];
  logic [11:0] par_s8  [16];
  logic [11:0] par_s7  [16];
  logic [11:0] exp_ped [16];
  logic [11:0] exp_s6  [16];
  logic [11:0] exp_s8  [16];
  logic [11:0] exp_s7  [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [191:0] obs,
                              input logic [191:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Parent 0 gets ped0, the rest pedr; symbols either track the parent
  // index (s8 = i, s7 = 0x100 + i) or are all set to csym.
  task automatic set_parents(input logic [11:0] ped0, input logic [11:0] pedr,
                             input bit const_sym, input logic [11:0] csym);
    for (int i = 0; i < 16; i++) begin
      par_ped[i] = (i == 0) ? ped0 : pedr;
      par_s8[i]  = const_sym ? csym : 12'(i);
      par_s7[i]  = const_sym ? csym : 12'(256 + i);
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] y6, input logic [11:0] r66,
                                input logic [11:0] r67, input logic [11:0] r68);
    bus.y6  = y6;
    bus.R66 = r66;
    bus.R67 = r67;
    bus.R68 = r68;
    for (int i = 0; i < 16; i++) begin
      bus.ped_in[i*12 +: 12]  = par_ped[i];
      bus.sym8_in[i*12 +: 12] = par_s8[i];
      bus.sym7_in[i*12 +: 12] = par_s7[i];
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with
  // out_valid high (or after the edge budget runs out).
  task automatic run_frame(input string name);
    int n;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_output({name, ".in_ready_run"}, 192'(bus.in_ready), 192'(0));
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_output({name, ".latency"}, 192'(n), 192'(65));
  endtask

  task automatic check_list(input string name);
    logic [191:0] e7, e8;
    e7 = '0;
    e8 = '0;
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("%s.ped[%0d]", name, i), 192'(bus.ped_out[i*12 +: 12]), 192'(exp_ped[i]));
      check_output($sformatf("%s.sym6[%0d]", name, i), 192'(bus.sym6_out[i*12 +: 12]), 192'(exp_s6[i]));
      e7[i*12 +: 12] = exp_s7[i];
      e8[i*12 +: 12] = exp_s8[i];
    end
    check_output({name, ".sym7"}, bus.sym7_out, e7);
    check_output({name, ".sym8"}, bus.sym8_out, e8);
  endtask

  task automatic release_frame(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_output({name, ".out_valid_after"}, 192'(bus.out_valid), 192'(0));
    check_output({name, ".in_ready_after"}, 192'(bus.in_ready), 192'(1));
  endtask

  // Entries 0..3 come from parent 0; the caller fills the tail.
  task automatic set_head(input logic [11:0] p0, input logic [11:0] p1,
                          input logic [11:0] p2, input logic [11:0] p3,
                          input logic [11:0] v0, input logic [11:0] v1,
                          input logic [11:0] v2, input logic [11:0] v3);
    exp_ped[0] = p0; exp_ped[1] = p1; exp_ped[2] = p2; exp_ped[3] = p3;
    exp_s6[0]  = v0; exp_s6[1]  = v1; exp_s6[2]  = v2; exp_s6[3]  = v3;
    for (int i = 0; i < 4; i++) begin
      exp_s8[i] = par_s8[0];
      exp_s7[i] = par_s7[0];
    end
  endtask

  // Nearest-4 window around r = 0, ties resolved by arrival.
  task automatic setup_t1();
    set_parents(12'h000, 12'h800, 1'b0, 12'h000);
    set_head(12'd5, 12'd5, 12'd54, 12'd54,
             12'(-39), 12'(39), 12'(-118), 12'(118));
    for (int i = 4; i < 16; i++) begin
      exp_ped[i] = 12'h805;
      exp_s6[i]  = (i % 2 == 0) ? 12'(-39) : 12'(39);
      exp_s8[i]  = 12'((i - 4) / 2 + 1);
      exp_s7[i]  = 12'(256 + (i - 4) / 2 + 1);
    end
    apply_stimulus(12'h000, 12'h100, 12'h000, 12'h000);
  endtask

  // r = 2.0: top window, d = 217 / 387 / 606 / 873.
  task automatic setup_t2();
    set_parents(12'h000, 12'h400, 1'b0, 12'h000);
    set_head(12'd217, 12'd387, 12'd606, 12'd873,
             12'd276, 12'd197, 12'd118, 12'd39);
    for (int i = 4; i < 16; i++) begin
      exp_ped[i] = 12'h4D9;
      exp_s6[i]  = 12'd276;
      exp_s8[i]  = 12'(i - 3);
      exp_s7[i]  = 12'(256 + i - 3);
    end
    apply_stimulus(12'h200, 12'h100, 12'h000, 12'h000);
  endtask

  initial begin
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.y6        = '0;
    bus.R66       = '0;
    bus.R67       = '0;
    bus.R68       = '0;
    bus.ped_in    = '0;
    bus.sym7_in   = '0;
    bus.sym8_in   = '0;

    #12;
    check_output("reset.in_ready", 192'(bus.in_ready), 192'(1));
    check_output("reset.out_valid", 192'(bus.out_valid), 192'(0));
    check_output("reset.ped_out", bus.ped_out, 192'(0));
    check_output("reset.sym6_out", bus.sym6_out, 192'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Nearest-4 window and tie order.
    setup_t1();
    run_frame("t1");
    check_list("t1");
    release_frame("t1");

    // Back-to-back frame: r = 0 + 1.0 - 0.5 = 0.5 (negative R68 product),
    // window s = 4, children d = 30 / 0 / 18 / 85.
    set_parents(12'h000, 12'h600, 1'b1, 12'h100);
    set_head(12'd0, 12'd18, 12'd30, 12'd85,
             12'd118, 12'd197, 12'd39, 12'd276);
    for (int i = 4; i < 16; i++) begin
      exp_ped[i] = 12'h600;
      exp_s6[i]  = 12'd118;
      exp_s8[i]  = 12'h100;
      exp_s7[i]  = 12'h100;
    end
    apply_stimulus(12'h000, 12'h100, 12'h080, 12'hF00);
    run_frame("t5");
    check_list("t5");
    release_frame("t5");

    // Edge window, then backpressure with in_valid toggling.
    setup_t2();
    run_frame("t2");
    check_list("t2");
    begin
      logic [191:0] ep, e6;
      for (int i = 0; i < 16; i++) begin
        ep[i*12 +: 12] = exp_ped[i];
        e6[i*12 +: 12] = exp_s6[i];
      end
      for (int c = 0; c < 10; c++) begin
        bus.in_valid = ~bus.in_valid;
        bus.ped_in   = ~bus.ped_in;
        @(posedge clk); #1;
        check_output($sformatf("bp%0d.in_ready", c), 192'(bus.in_ready), 192'(0));
        check_output($sformatf("bp%0d.out_valid", c), 192'(bus.out_valid), 192'(1));
        check_output($sformatf("bp%0d.ped_out", c), bus.ped_out, ep);
        check_output($sformatf("bp%0d.sym6_out", c), bus.sym6_out, e6);
      end
      bus.in_valid = 1'b0;
    end
    release_frame("t4");

    // Saturation: every child PED clamps to 0xFFF; arrival order kept.
    set_parents(12'hFF0, 12'hFF0, 1'b0, 12'h000);
    for (int i = 0; i < 16; i++) begin
      exp_ped[i] = 12'hFFF;
      case (i % 4)
        0:       exp_s6[i] = 12'd39;
        1:       exp_s6[i] = 12'd118;
        2:       exp_s6[i] = 12'd197;
        default: exp_s6[i] = 12'd276;
      endcase
      exp_s8[i] = 12'(i / 4);
      exp_s7[i] = 12'(256 + i / 4);
    end
    apply_stimulus(12'h7FF, 12'h100, 12'h000, 12'h000);
    run_frame("t3");
    check_list("t3");
    release_frame("t3");

    // Reset mid-RUN at cnt = 30.
    setup_t2();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_output("t6.out_valid", 192'(bus.out_valid), 192'(0));
    check_output("t6.in_ready", 192'(bus.in_ready), 192'(1));
    check_output("t6.ped_out", bus.ped_out, 192'(0));
    check_output("t6.sym6_out", bus.sym6_out, 192'(0));
    check_output("t6.sym7_out", bus.sym7_out, 192'(0));
    check_output("t6.sym8_out", bus.sym8_out, 192'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_output("t6.in_ready_rel", 192'(bus.in_ready), 192'(1));
    check_output("t6.out_valid_rel", 192'(bus.out_valid), 192'(0));
    setup_t1();
    run_frame("t6b");
    check_list("t6b");
    release_frame("t6b");

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
